// File: rtl/alu_mdu_dec_if.sv
// Execute-stage bus between the control path and the ALU decoder / MD unit.
interface alu_mdu_dec_if #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             start;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [CTL_W-1:0] alu_ctl;
  logic             ext_op;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  op, funct, start, srca, srcb,
    output alu_ctl, ext_op, md_busy, md_done, md_result, stall, hi, lo
  );

  modport master (
    output op, funct, start, srca, srcb,
    input  alu_ctl, ext_op, md_busy, md_done, md_result, stall, hi, lo
  );
endinterface

// File: rtl/alu_mdu_dec.sv
// ALU control decoder plus HI/LO register pair and iterative mult/div engine.
module alu_mdu_dec #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_mdu_dec_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;      // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_a;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_srca;   // raw dividend for the divide-by-zero result
  logic               r_sn, r_sa, r_dz, r_div;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_busy, r_done;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v);
    return (~v) + (2*WIDTH)'(1);
  endfunction

  // Instruction classification shared by decoder, engine and stall logic.
  logic w_rtype, w_md_fn, w_is_mul, w_is_div, w_is_mthi, w_is_mtlo, w_signed, w_idle_go;
  assign w_rtype   = (bus.op == 6'b000000);
  assign w_md_fn   = w_rtype && (bus.funct[5:4] == 2'b01) && (bus.funct[2] == 1'b0);
  assign w_is_mul  = w_rtype && (bus.funct[5:1] == 5'b01100);
  assign w_is_div  = w_rtype && (bus.funct[5:1] == 5'b01101);
  assign w_is_mthi = w_rtype && (bus.funct == 6'b010001);
  assign w_is_mtlo = w_rtype && (bus.funct == 6'b010011);
  assign w_signed  = ~bus.funct[0];
  assign w_idle_go = bus.start && (r_state == S_IDLE);

  // Operand magnitudes; unsigned variants pass raw values.
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_abs_a = (w_signed && bus.srca[WIDTH-1]) ? f_neg(bus.srca) : bus.srca;
  assign w_abs_b = (w_signed && bus.srcb[WIDTH-1]) ? f_neg(bus.srcb) : bus.srcb;

  // One shift-add step and one restoring-divide step.
  logic [WIDTH:0]   w_sum, w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_a});
  assign w_diff  = w_shift[WIDTH-1:0] - r_a;

  // Sign fix-up applied in the final state.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  assign w_prod = r_sn ? f_neg2(r_p) : r_p;
  assign w_quo  = r_dz ? {WIDTH{1'b1}} : (r_sn ? f_neg(r_p[WIDTH-1:0]) : r_p[WIDTH-1:0]);
  assign w_rem  = r_dz ? r_srca : (r_sa ? f_neg(r_p[2*WIDTH-1:WIDTH]) : r_p[2*WIDTH-1:WIDTH]);

  // ALU control and immediate-extension decode.
  logic [3:0] w_ctl;
  always_comb begin
    w_ctl = 4'b0000;
    if (w_rtype) begin
      case (bus.funct)
        6'b100000, 6'b100001: w_ctl = 4'b0010;
        6'b100010, 6'b100011: w_ctl = 4'b0110;
        6'b100100:            w_ctl = 4'b0000;
        6'b100101:            w_ctl = 4'b0001;
        6'b100110:            w_ctl = 4'b0011;
        6'b100111:            w_ctl = 4'b0100;
        6'b101010:            w_ctl = 4'b0111;
        6'b101011:            w_ctl = 4'b1000;
        default:              w_ctl = 4'b0000;
      endcase
    end else begin
      case (bus.op)
        6'b001000, 6'b001001: w_ctl = 4'b0010;
        6'b001100:            w_ctl = 4'b0000;
        6'b001101:            w_ctl = 4'b0001;
        6'b001110:            w_ctl = 4'b0011;
        6'b001010:            w_ctl = 4'b0111;
        6'b001011:            w_ctl = 4'b1000;
        6'b001111:            w_ctl = 4'b1001;
        6'b100011, 6'b101011: w_ctl = 4'b0010;
        6'b000100, 6'b000101: w_ctl = 4'b0110;
        default:              w_ctl = 4'b0000;
      endcase
    end
  end

  // Combinational outputs: decode, move-from result and stall.
  always_comb begin
    bus.alu_ctl   = CTL_W'(w_ctl);
    bus.ext_op    = 1'b1;
    bus.md_result = {WIDTH{1'b0}};
    bus.stall     = 1'b0;
    case (bus.op)
      6'b001100, 6'b001101, 6'b001110, 6'b001111: bus.ext_op = 1'b0;
      default:                                    bus.ext_op = 1'b1;
    endcase
    if (w_rtype && (bus.funct == 6'b010000)) begin
      bus.md_result = r_hi;
    end else if (w_rtype && (bus.funct == 6'b010010)) begin
      bus.md_result = r_lo;
    end else begin
      bus.md_result = {WIDTH{1'b0}};
    end
    if (bus.start && w_md_fn && (r_state != S_IDLE)) begin
      bus.stall = 1'b1;
    end else begin
      bus.stall = 1'b0;
    end
  end

  // Engine next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_idle_go && w_is_mul) begin
          w_next = S_MUL;
        end else if (w_idle_go && w_is_div) begin
          w_next = S_DIV;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_next = S_FIX;
        end else begin
          w_next = r_state;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Engine state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Engine datapath, HI/LO writes and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_p    <= {(2*WIDTH){1'b0}};
      r_a    <= {WIDTH{1'b0}};
      r_srca <= {WIDTH{1'b0}};
      r_sn   <= 1'b0;
      r_sa   <= 1'b0;
      r_dz   <= 1'b0;
      r_div  <= 1'b0;
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_idle_go && (w_is_mul || w_is_div)) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_div  <= w_is_div;
            r_srca <= bus.srca;
            r_sn   <= w_signed && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            r_sa   <= w_signed && bus.srca[WIDTH-1];
            r_dz   <= w_is_div && (bus.srcb == {WIDTH{1'b0}});
            r_a    <= w_is_div ? w_abs_b : w_abs_a;
            r_p    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
          end else if (w_idle_go && w_is_mthi) begin
            r_hi <= bus.srca;
          end else if (w_idle_go && w_is_mtlo) begin
            r_lo <= bus.srca;
          end
        end
        S_MUL: begin
          r_p   <= {w_sum, r_p[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DIV: begin
          r_p   <= {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_hi   <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
          r_lo   <= r_div ? w_quo : w_prod[WIDTH-1:0];
          r_done <= 1'b1;
        end
        default: r_cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign bus.md_busy = r_busy;
  assign bus.md_done = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
endmodule
